// File: rtl/video_src_sched.sv
// Frame-synchronous two-source video scheduler with an src1 vsync watchdog.
// Optional macro VSEL_BLANK_TIMING_EN: during BLANK, keep src0 timing and drive BLANK_RGB.
module video_src_sched #(
  parameter int                 DATA_W         = 24,
  parameter int                 TIMEOUT_CYCLES = 1500000,
  parameter int                 CNT_W          = 21,
  parameter logic [DATA_W-1:0]  BLANK_RGB      = '0
) (
  input  logic              vsel_clk_i,
  input  logic              vsel_rstn_i,
  input  logic              sel_i,
  input  logic              src0_vs_i,
  input  logic              src0_hs_i,
  input  logic              src0_de_i,
  input  logic [DATA_W-1:0] src0_data_i,
  input  logic              src1_vs_i,
  input  logic              src1_hs_i,
  input  logic              src1_de_i,
  input  logic [DATA_W-1:0] src1_data_i,
  output logic              vout_vs_o,
  output logic              vout_hs_o,
  output logic              vout_de_o,
  output logic [DATA_W-1:0] vout_data_o,
  output logic              act_src_o,
  output logic              src1_alive_o,
  output logic              switch_pend_o
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  if ((2.0 ** CNT_W) <= TIMEOUT_CYCLES || $bits(BLANK_RGB) != DATA_W) begin : g_param_chk
    $error("video_src_sched: CNT_W too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_BLANK} state_e;

  state_e            state_q, state_d;
  logic              act_q, act_d, tgt_q, tgt_d;
  logic              vs0_q, vs1_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              alive_q, alive_d;
  logic              vs_q, vs_d, hs_q, hs_d, de_q, de_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic vs0_rise, vs1_rise, act_rise, tgt_rise, fallback;

  assign vs0_rise = src0_vs_i & ~vs0_q;
  assign vs1_rise = src1_vs_i & ~vs1_q;
  assign act_rise = act_q ? vs1_rise : vs0_rise;
  assign tgt_rise = tgt_q ? vs1_rise : vs0_rise;
  // running on src1 while its watchdog says dead
  assign fallback = act_q & ~alive_q;

  // Watchdog: a vs_rise in the timeout cycle keeps src1 alive.
  always_comb begin
    cnt_d = cnt_q;
    if (vs1_rise)          cnt_d = '0;
    else if (cnt_q != TMO) cnt_d = cnt_q + 1'b1;
    alive_d = vs1_rise | (alive_q & (cnt_d != TMO));
  end

  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_RUN: begin
        if (fallback) begin
          state_d = ST_BLANK;
          tgt_d   = 1'b0;
        end else if (sel_i != act_q && (act_q || alive_q)) begin
          state_d = ST_DRAIN;
          tgt_d   = ~act_q;
        end
      end
      ST_DRAIN: begin
        if (sel_i == act_q) begin
          state_d = ST_RUN;
        end else if (fallback) begin
          state_d = ST_BLANK;
          tgt_d   = 1'b0;
        end else if (!act_q && !alive_q) begin
          state_d = ST_RUN;
        end else if (act_rise) begin
          state_d = ST_BLANK;
          tgt_d   = ~act_q;
        end
      end
      ST_BLANK: begin
        if (tgt_rise) begin
          act_d   = tgt_q;
          state_d = ST_RUN;
        end else if (tgt_q && !alive_q) begin
          tgt_d = 1'b0;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output mux follows the next state so the new source's vs lands on the switch edge.
  always_comb begin
    vs_d   = 1'b0;
    hs_d   = 1'b0;
    de_d   = 1'b0;
    data_d = '0;
    if (state_d != ST_BLANK) begin
      if (act_d) begin
        vs_d = src1_vs_i; hs_d = src1_hs_i; de_d = src1_de_i; data_d = src1_data_i;
      end else begin
        vs_d = src0_vs_i; hs_d = src0_hs_i; de_d = src0_de_i; data_d = src0_data_i;
      end
    end else begin
`ifdef VSEL_BLANK_TIMING_EN
      vs_d   = src0_vs_i;
      hs_d   = src0_hs_i;
      de_d   = src0_de_i;
      data_d = src0_de_i ? BLANK_RGB : '0;
`endif
    end
  end

  always_ff @(posedge vsel_clk_i or negedge vsel_rstn_i) begin
    if (!vsel_rstn_i) begin
      state_q <= ST_RUN;
      act_q   <= 1'b0;
      tgt_q   <= 1'b0;
      vs0_q   <= 1'b0;
      vs1_q   <= 1'b0;
      cnt_q   <= '0;
      alive_q <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      tgt_q   <= tgt_d;
      vs0_q   <= src0_vs_i;
      vs1_q   <= src1_vs_i;
      cnt_q   <= cnt_d;
      alive_q <= alive_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      data_q  <= data_d;
    end
  end

  assign vout_vs_o     = vs_q;
  assign vout_hs_o     = hs_q;
  assign vout_de_o     = de_q;
  assign vout_data_o   = data_q;
  assign act_src_o     = act_q;
  assign src1_alive_o  = alive_q;
  assign switch_pend_o = sel_i ^ act_q;

endmodule

// File: tb/tb_video_src_sched.sv
// Directed bench for video_src_sched: table of steady-state steps plus switch/timeout sequences.
module tb_video_src_sched;
  localparam int DATA_W = 24;
  localparam int TMO    = 1000;
  localparam int P0     = 300;
  localparam int P1     = 500;
  localparam logic [DATA_W-1:0] RGB = 24'h0000FF;

  logic clk = 1'b0;
  logic rst_n;
  logic sel;
  logic s0_vs, s0_hs, s0_de, s1_vs, s1_hs, s1_de;
  logic [DATA_W-1:0] s0_data, s1_data;
  logic o_vs, o_hs, o_de, act, alive, pend;
  logic [DATA_W-1:0] o_data;

  int n_chk = 0, n_fail = 0;
  int c0 = 0, c1 = 0;
  bit s1_en = 1'b0;

  always #5 clk = ~clk;

  video_src_sched #(.DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .CNT_W(11), .BLANK_RGB(RGB)) dut (
    .vsel_clk_i(clk), .vsel_rstn_i(rst_n), .sel_i(sel),
    .src0_vs_i(s0_vs), .src0_hs_i(s0_hs), .src0_de_i(s0_de), .src0_data_i(s0_data),
    .src1_vs_i(s1_vs), .src1_hs_i(s1_hs), .src1_de_i(s1_de), .src1_data_i(s1_data),
    .vout_vs_o(o_vs), .vout_hs_o(o_hs), .vout_de_o(o_de), .vout_data_o(o_data),
    .act_src_o(act), .src1_alive_o(alive), .switch_pend_o(pend));

  // Sources advance on the falling edge; vs is high for the first 3 cycles of a frame.
  always @(negedge clk) begin
    c0 = (c0 == P0-1) ? 0 : c0 + 1;
    if (s1_en) c1 = (c1 == P1-1) ? 0 : c1 + 1;
    s0_vs = (c0 < 3); s0_hs = ((c0 % 20) < 2); s0_de = (c0 >= 20) && ((c0 % 20) >= 4);
    s0_data = {8'hA0, 16'(c0)};
    s1_vs = s1_en && (c1 < 3); s1_hs = s1_en && ((c1 % 20) < 2);
    s1_de = s1_en && (c1 >= 20) && ((c1 % 20) >= 4);
    s1_data = s1_en ? {8'hB1, 16'(c1)} : '0;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // mode 0: src0 passthrough, 1: src1 passthrough, 2: blank
  function automatic logic [31:0] exp_out(input int mode);
    case (mode)
      0: return {5'd0, s0_vs, s0_hs, s0_de, s0_data};
      1: return {5'd0, s1_vs, s1_hs, s1_de, s1_data};
`ifdef VSEL_BLANK_TIMING_EN
      default: return {5'd0, s0_vs, s0_hs, s0_de, (s0_de ? RGB : 24'h0)};
`else
      default: return 32'h0;
`endif
    endcase
  endfunction

  function automatic logic [31:0] got_out();
    return {5'd0, o_vs, o_hs, o_de, o_data};
  endfunction

  task automatic wait_c0(input int v, input int maxc, input string nm);
    int k = 0;
    do begin tick(); k++; end while (c0 != v && k < maxc);
    chk(nm, c0, v);
  endtask

  task automatic wait_c1(input int v, input int maxc, input string nm);
    int k = 0;
    do begin tick(); k++; end while (c1 != v && k < maxc);
    chk(nm, c1, v);
  endtask

  typedef struct {
    logic sel; bit s1_on; int ncyc;
    logic exp_act; logic exp_alive; logic exp_pend; int exp_mode;
  } step_t;

  step_t steps[5];

  initial begin
    int bad;
    steps[0] = '{1'b0, 1'b0,  40, 1'b0, 1'b0, 1'b0, 0};
    steps[1] = '{1'b0, 1'b0, 400, 1'b0, 1'b0, 1'b0, 0};
    steps[2] = '{1'b1, 1'b0,   5, 1'b0, 1'b0, 1'b1, 0};
    steps[3] = '{1'b1, 1'b0, 700, 1'b0, 1'b0, 1'b1, 0};
    steps[4] = '{1'b0, 1'b0,   3, 1'b0, 1'b0, 1'b0, 0};

    rst_n = 1'b0; sel = 1'b0;
    tick(6);
    chk("reset_vout", got_out(), 32'h0);
    chk("reset_act", act, 0);
    chk("reset_alive", alive, 0);
    @(negedge clk); rst_n = 1'b1;

    foreach (steps[r]) begin
      sel = steps[r].sel; s1_en = steps[r].s1_on;
      bad = 0;
      for (int i = 0; i < steps[r].ncyc; i++) begin
        tick();
        if (got_out() !== exp_out(steps[r].exp_mode)) bad++;
      end
      chk($sformatf("step%0d_mode_errs", r), bad, 0);
      chk($sformatf("step%0d_act", r), act, steps[r].exp_act);
      chk($sformatf("step%0d_alive", r), alive, steps[r].exp_alive);
      chk($sformatf("step%0d_pend", r), pend, steps[r].exp_pend);
    end

    // src1 comes up; switch requested mid src0 frame
    s1_en = 1'b1; c1 = P1 - 1;
    wait_c1(0, 10, "s1_first_rise");
    chk("s1_alive", alive, 1);
    wait_c0(150, 400, "mid_frame");
    sel = 1'b1;
    tick();
    chk("drain_pend", pend, 1);
    chk("drain_out", got_out(), exp_out(0));
    wait_c0(0, 400, "drain_s0_rise");
    chk("blank_out", got_out(), exp_out(2));
    chk("blank_act", act, 0);
    wait_c1(0, 1200, "blank_s1_rise");
    chk("sw_act", act, 1);
    chk("sw_out", got_out(), exp_out(1));
    chk("sw_pend", pend, 0);
    tick(37);
    chk("sw_out_later", got_out(), exp_out(1));

    // src1 stops right after a vs rise; watchdog expires TMO edges later
    wait_c1(0, 600, "last_s1_rise");
    s1_en = 1'b0;
    tick(TMO - 1);
    chk("wd_alive_before", alive, 1);
    tick();
    chk("wd_alive_after", alive, 0);
    tick();
    chk("fb_blank_out", got_out(), exp_out(2));
    chk("fb_blank_act", act, 1);
    wait_c0(0, 400, "fb_s0_rise");
    chk("fb_act", act, 0);
    chk("fb_out", got_out(), exp_out(0));
    chk("fb_pend", pend, 1);

    // revert in the same cycle as the active-source vs rise
    s1_en = 1'b1; c1 = P1 - 1;
    wait_c1(0, 10, "s1_back_rise");
    chk("s1_back_alive", alive, 1);
    wait_c0(P0 - 1, 400, "pre_s0_rise");
    sel = 1'b0;
    tick();
    chk("revert_act", act, 0);
    chk("revert_out", got_out(), exp_out(0));
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (got_out() !== exp_out(0)) bad++;
    end
    chk("revert_no_blank", bad, 0);
    chk("revert_pend", pend, 0);

    // switch to src1 again, then reset mid-operation
    sel = 1'b1;
    begin
      int k = 0;
      do begin tick(); k++; end while (act !== 1'b1 && k < 2000);
      chk("resw_act", act, 1);
    end
    s1_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_vout", got_out(), 32'h0);
    chk("async_rst_act", act, 0);
    chk("async_rst_alive", alive, 0);
    @(negedge clk); rst_n = 1'b1;
    tick(20);
    chk("post_rst_act", act, 0);
    chk("post_rst_alive", alive, 0);
    chk("post_rst_pend", pend, 1);
    chk("post_rst_out", got_out(), exp_out(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
